// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 pipelined core front end.
// Contents:
//   DEF_ADDR_W / DEF_INSTR_W : default address and instruction widths
//   NOP_INSTR                : architectural NOP encoding loaded into IF/ID on reset and squash
//   fetch_state_t            : fetch sequencer states
//   low_bits_mask()          : mask of the byte-offset bits below one instruction step
package cpu_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    // Offset bits below an instruction step; assumes the step is a power of two.
    function automatic logic [63:0] low_bits_mask(input int unsigned step);
        return 64'(step) - 64'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its surroundings.
// master (fetch stage): drives imem_addr and the IF/ID outputs, receives
//   stall, redirect_valid, redirect_pc and imem_rdata.
// slave (memory / downstream pipeline): the mirror image.
interface fetch_stage_if #(
    parameter int ADDR_W  = cpu_pkg::DEF_ADDR_W,
    parameter int INSTR_W = cpu_pkg::DEF_INSTR_W
);
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ifid_valid;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [ADDR_W-1:0]  ifid_pc_plus;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus
    );
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter used for fetch statistics.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : count enable for this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_r;

    // Increment while enabled until the all-ones ceiling is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, addresses instruction memory and
// registers each fetched instruction into the IF/ID pipeline register.
// Ports:
//   clk            : core clock
//   reset          : asynchronous active-low reset
//   bus (master)   : stall / redirect inputs, imem address/data, IF/ID outputs
//   misalign_fault : sticky flag, a redirect target had nonzero offset bits
//   fetch_count    : saturating count of instructions accepted into IF/ID
//   squash_count   : saturating count of live IF/ID slots killed by redirect
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    bus,
    output logic             misalign_fault,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] squash_count
);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] LOW_MASK   = ADDR_W'(low_bits_mask(PC_STEP));
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~LOW_MASK;

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic               ifid_valid_r;
    logic [INSTR_W-1:0] ifid_instr_r;
    logic [ADDR_W-1:0]  ifid_pc_r;
    logic [ADDR_W-1:0]  ifid_pc_plus_r;
    logic               misalign_fault_r;

    logic               active_s;
    logic               take_redirect_s;
    logic               advance_s;
    logic               squash_inc_s;
    logic               misaligned_s;
    logic [ADDR_W-1:0]  redirect_target_s;
    logic [ADDR_W-1:0]  pc_seq_s;

    // Decode this cycle's action; BOOT ignores both stall and redirect.
    always_comb begin
        active_s          = (state_r != BOOT);
        take_redirect_s   = active_s & bus.redirect_valid;
        advance_s         = active_s & ~bus.redirect_valid & ~bus.stall;
        squash_inc_s      = take_redirect_s & ifid_valid_r;
        misaligned_s      = |(bus.redirect_pc & LOW_MASK);
        redirect_target_s = bus.redirect_pc & ALIGN_MASK;
        pc_seq_s          = pc_r + STEP;
    end

    // Fetch sequencer: PC, IF/ID register and sticky fault in one block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= BOOT;
            pc_r             <= RESET_PC;
            ifid_valid_r     <= 1'b0;
            ifid_instr_r     <= INSTR_W'(NOP_INSTR);
            ifid_pc_r        <= {ADDR_W{1'b0}};
            ifid_pc_plus_r   <= {ADDR_W{1'b0}};
            misalign_fault_r <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r <= RUN;
                end
                RUN, SQUASH: begin
                    if (bus.redirect_valid) begin
                        // Redirect beats stall; the slot in IF/ID becomes a bubble.
                        state_r          <= SQUASH;
                        pc_r             <= redirect_target_s;
                        ifid_valid_r     <= 1'b0;
                        ifid_instr_r     <= INSTR_W'(NOP_INSTR);
                        misalign_fault_r <= misalign_fault_r | misaligned_s;
                    end else if (bus.stall) begin
                        // A stalled SQUASH cycle still counts as the recovery cycle.
                        state_r <= RUN;
                    end else begin
                        state_r        <= RUN;
                        pc_r           <= pc_seq_s;
                        ifid_valid_r   <= 1'b1;
                        ifid_instr_r   <= bus.imem_rdata;
                        ifid_pc_r      <= pc_r;
                        ifid_pc_plus_r <= pc_seq_s;
                    end
                end
                default: begin
                    state_r      <= BOOT;
                    ifid_valid_r <= 1'b0;
                    ifid_instr_r <= INSTR_W'(NOP_INSTR);
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (advance_s),
        .count (fetch_count)
    );

    sat_counter #(.W(CNT_W)) u_squash_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (squash_inc_s),
        .count (squash_count)
    );

    assign bus.imem_addr    = pc_r;
    assign bus.ifid_valid   = ifid_valid_r;
    assign bus.ifid_instr   = ifid_instr_r;
    assign bus.ifid_pc      = ifid_pc_r;
    assign bus.ifid_pc_plus = ifid_pc_plus_r;
    assign misalign_fault   = misalign_fault_r;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP    = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        fault0, fault1;
    logic [31:0] fc0, sc0;
    logic [1:0]  fc1, sc1;

    always #5 clk = ~clk;

    // Memory contents: address 0,4,8 hold 0x91000421, 0x91000842, 0x91000C63, ...
    function automatic logic [31:0] instr_at(input logic [63:0] a);
        return 32'h91000421 + a[33:2] * 32'h421;
    endfunction

    fetch_stage_if #(.ADDR_W(64), .INSTR_W(32)) bus0 ();
    fetch_stage_if #(.ADDR_W(64), .INSTR_W(32)) bus1 ();

    assign bus0.stall          = stall;
    assign bus0.redirect_valid = redirect_valid;
    assign bus0.redirect_pc    = redirect_pc;
    assign bus0.imem_rdata     = instr_at(bus0.imem_addr);
    assign bus1.stall          = stall;
    assign bus1.redirect_valid = redirect_valid;
    assign bus1.redirect_pc    = redirect_pc;
    assign bus1.imem_rdata     = instr_at(bus1.imem_addr);

    fetch_stage dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master),
        .misalign_fault(fault0), .fetch_count(fc0), .squash_count(sc0)
    );

    fetch_stage #(.RESET_PC(TOP_PC), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master),
        .misalign_fault(fault1), .fetch_count(fc1), .squash_count(sc1)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] ifpc;
        logic [63:0] ifplus;
        logic [31:0] instr;
        logic [31:0] fc;
        logic [31:0] sc;
        logic        valid;
        logic        fault;
        logic        boot;
    } mstate_t;

    mstate_t m [2];

    function automatic logic [31:0] cmax(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'd3;
    endfunction

    function automatic mstate_t m_init(input int k);
        mstate_t s;
        s        = '0;
        s.pc     = (k == 0) ? 64'd0 : TOP_PC;
        s.instr  = NOP;
        s.boot   = 1'b1;
        return s;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input int k);
        mstate_t n;
        n = s;
        if (s.boot) begin
            n.boot = 1'b0;
        end else if (redirect_valid) begin
            n.pc    = {redirect_pc[63:2], 2'b00};
            n.fault = s.fault | (redirect_pc[1:0] != 2'b00);
            if (s.valid && s.sc != cmax(k)) n.sc = s.sc + 32'd1;
            n.valid = 1'b0;
            n.instr = NOP;
        end else if (!stall) begin
            n.instr  = instr_at(s.pc);
            n.ifpc   = s.pc;
            n.ifplus = s.pc + 64'd4;
            n.valid  = 1'b1;
            n.pc     = s.pc + 64'd4;
            if (s.fc != cmax(k)) n.fc = s.fc + 32'd1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m[0] <= m_init(0);
            m[1] <= m_init(1);
        end else begin
            m[0] <= m_step(m[0], 0);
            m[1] <= m_step(m[1], 1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0_addr",   bus0.imem_addr,          m[0].pc);
            chk("d0_valid",  64'(bus0.ifid_valid),    64'(m[0].valid));
            chk("d0_instr",  64'(bus0.ifid_instr),    64'(m[0].instr));
            chk("d0_pc",     bus0.ifid_pc,            m[0].ifpc);
            chk("d0_plus",   bus0.ifid_pc_plus,       m[0].ifplus);
            chk("d0_fault",  64'(fault0),             64'(m[0].fault));
            chk("d0_fc",     64'(fc0),                64'(m[0].fc));
            chk("d0_sc",     64'(sc0),                64'(m[0].sc));
            chk("d1_addr",   bus1.imem_addr,          m[1].pc);
            chk("d1_valid",  64'(bus1.ifid_valid),    64'(m[1].valid));
            chk("d1_instr",  64'(bus1.ifid_instr),    64'(m[1].instr));
            chk("d1_pc",     bus1.ifid_pc,            m[1].ifpc);
            chk("d1_plus",   bus1.ifid_pc_plus,       m[1].ifplus);
            chk("d1_fault",  64'(fault1),             64'(m[1].fault));
            chk("d1_fc",     64'(fc1),                64'(m[1].fc));
            chk("d1_sc",     64'(sc1),                64'(m[1].sc));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        repeat (2) tick();
        chk("rst_valid", 64'(bus0.ifid_valid), 64'd0);
        chk("rst_instr", 64'(bus0.ifid_instr), 64'(NOP));
        chk("rst_addr1", bus1.imem_addr, TOP_PC);
        chk_en = 1'b1;

        // BOOT edge: stall and redirect are both ignored
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
        tick();
        chk("boot_addr", bus0.imem_addr, 64'h0);
        chk("boot_valid", 64'(bus0.ifid_valid), 64'd0);

        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        chk("f0_pc", bus0.ifid_pc, 64'h0);
        chk("f0_instr", 64'(bus0.ifid_instr), 64'h91000421);
        chk("wrap_addr1", bus1.imem_addr, 64'h0);
        chk("wrap_pc1", bus1.ifid_pc, TOP_PC);
        tick();
        chk("f1_pc", bus0.ifid_pc, 64'h4);
        chk("f1_instr", 64'(bus0.ifid_instr), 64'h91000842);

        stall = 1'b1;
        tick();
        tick();
        chk("stall_addr", bus0.imem_addr, 64'h8);
        chk("stall_pc", bus0.ifid_pc, 64'h4);
        chk("stall_fc", 64'(fc0), 64'd2);

        stall = 1'b0;
        tick();
        chk("f2_pc", bus0.ifid_pc, 64'h8);
        chk("f2_instr", 64'(bus0.ifid_instr), 64'h91000C63);
        chk("f2_fc", 64'(fc0), 64'd3);

        redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        chk("rd_valid", 64'(bus0.ifid_valid), 64'd0);
        chk("rd_instr", 64'(bus0.ifid_instr), 64'(NOP));
        chk("rd_sc", 64'(sc0), 64'd1);
        chk("rd_addr", bus0.imem_addr, 64'h40);
        chk("model_pc", m[0].pc, 64'h40);

        redirect_valid = 1'b0;
        tick();
        chk("tgt_pc", bus0.ifid_pc, 64'h40);
        chk("tgt_valid", 64'(bus0.ifid_valid), 64'd1);
        chk("tgt_instr", 64'(bus0.ifid_instr), 64'h91004631);
        chk("sat_fc1", 64'(fc1), 64'd3);

        redirect_valid = 1'b1; redirect_pc = 64'h100; stall = 1'b1;
        tick();
        chk("rs_addr", bus0.imem_addr, 64'h100);
        chk("rs_valid", 64'(bus0.ifid_valid), 64'd0);
        chk("rs_sc", 64'(sc0), 64'd2);

        redirect_pc = 64'h42; stall = 1'b0;
        tick();
        chk("mis_addr", bus0.imem_addr, 64'h40);
        chk("mis_fault", 64'(fault0), 64'd1);
        chk("mis_sc", 64'(sc0), 64'd2);

        redirect_pc = 64'h80;
        tick();
        chk("sticky_fault", 64'(fault0), 64'd1);
        chk("sticky_addr", bus0.imem_addr, 64'h80);
        redirect_valid = 1'b0;
        tick();
        chk("post_pc", bus0.ifid_pc, 64'h80);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(5) == 0);
            case ($urandom_range(3))
                0: redirect_pc = {32'($urandom), 32'($urandom)} & ~64'd3;
                1: redirect_pc = 64'($urandom_range(4095)) & ~64'd3;
                2: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                default: redirect_pc = 64'($urandom_range(255));
            endcase
            tick();
        end

        // asynchronous reset in the middle of a stall
        stall = 1'b1; redirect_valid = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(bus0.ifid_valid), 64'd0);
        chk("ar_instr", 64'(bus0.ifid_instr), 64'(NOP));
        chk("ar_pc", bus0.ifid_pc, 64'd0);
        chk("ar_plus", bus0.ifid_pc_plus, 64'd0);
        chk("ar_addr", bus0.imem_addr, 64'd0);
        chk("ar_fault", 64'(fault0), 64'd0);
        chk("ar_fc", 64'(fc0), 64'd0);
        chk("ar_sc", 64'(sc0), 64'd0);
        chk("ar_addr1", bus1.imem_addr, TOP_PC);
        tick();
        tick();
        reset = 1'b1; stall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(6) == 0);
            redirect_pc    = 64'($urandom_range(1023));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch front end for the pipelined successor of the single-cycle LEGv8 core.
- Owns the PC, drives the instruction-memory address, and registers each fetched instruction into the IF/ID pipeline register.
- Supports stall, redirect (branch/BR resolved downstream), and squash.
- Keeps saturating fetch and squash counters for performance analysis.

Parameters:
- ADDR_W, 64, PC and address width in bits.
- INSTR_W, 32, instruction width in bits.
- PC_STEP, 4, sequential PC increment in bytes.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; state is cleared while reset==0.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid  in  1  a branch was taken downstream; load redirect_pc.
- redirect_pc  in  ADDR_W  branch or BR target.
- imem_addr  out  ADDR_W  instruction-memory address; equals the current PC (combinational).
- imem_rdata  in  INSTR_W  instruction at imem_addr, valid in the same cycle.
- ifid_valid  out  1  IF/ID register holds a live instruction.
- ifid_instr  out  INSTR_W  registered instruction.
- ifid_pc  out  ADDR_W  PC of ifid_instr.
- ifid_pc_plus  out  ADDR_W  ifid_pc + PC_STEP, used for BL link.
- misalign_fault  out  1  sticky; set when a redirect target is not PC_STEP-aligned.
- fetch_count  out  CNT_W  instructions accepted into IF/ID.
- squash_count  out  CNT_W  IF/ID slots killed by redirect.

Behaviour:
- Reset (reset==0, asynchronous) sets the following:
  - pc=RESET_PC, state=BOOT.
  - ifid_valid=0, ifid_instr=NOP (0xD503201F), ifid_pc=0, ifid_pc_plus=0.
  - misalign_fault=0, both counters=0.
- FSM states:
  - BOOT: one cycle after reset release. No IF/ID capture; ifid_valid stays 0 and pc is held. Moves to RUN unconditionally, ignoring stall and redirect.
  - RUN: normal fetch.
  - SQUASH: the one cycle after a redirect. Returns to RUN.
- Priority in RUN and SQUASH: redirect_valid > stall > advance.
- Advance:
  - pc <= pc + PC_STEP, modulo 2^ADDR_W (wraps, no fault).
  - ifid_instr <= imem_rdata, ifid_pc <= pc, ifid_pc_plus <= pc + PC_STEP.
  - ifid_valid <= 1; fetch_count increments.
- Stall: pc, all ifid_* outputs, and the counters are held. Stall in SQUASH still leaves SQUASH for RUN.
- Redirect:
  - pc <= redirect_pc with the low log2(PC_STEP) bits cleared.
  - ifid_valid <= 0, ifid_instr <= NOP.
  - squash_count increments only if ifid_valid was 1.
  - State goes to SQUASH.
- Redirect together with stall: the redirect wins; the stall is dropped for that cycle.
- Redirect in SQUASH: accepted again, and the state remains SQUASH.
- misalign_fault is set on any accepted redirect whose low bits are nonzero. Only reset clears it.
- Counters saturate at all-ones and do not wrap.
- Latency: the instruction at pc appears on ifid_* one cycle after an advance edge. After a redirect, the first valid target instruction appears two edges later, giving exactly one bubble.
- Reset asserted mid-operation discards all state immediately and behaves exactly as a power-on reset.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - NOP_INSTR = 32'hD503201F.
  - Enum fetch_state_t {BOOT, RUN, SQUASH}.
- One natural sub-module, sat_counter (width CNT_W, inc enable, async active-low clear), instantiated twice.

Test Plan:
- Reset release, then 3 clean cycles with imem returning 0x91000421, 0x91000842, 0x91000C63:
  - BOOT cycle: ifid_valid=0.
  - Next edges: ifid_pc=0,4,8 with those instructions.
  - fetch_count=3.
- Stall held 2 cycles at pc=8: imem_addr stays 8, ifid_* unchanged, fetch_count unchanged. Release resumes at 8.
- redirect_valid with redirect_pc=0x40 while ifid_valid=1:
  - Next cycle: ifid_valid=0, ifid_instr=NOP, squash_count=1, imem_addr=0x40.
  - Following edge: ifid_pc=0x40, ifid_valid=1.
- Redirect and stall in the same cycle, with redirect_pc=0x100: redirect taken, imem_addr=0x100, state SQUASH.
- redirect_pc=0x42: imem_addr=0x40, misalign_fault=1, and it stays 1 through later redirects until reset.
- Edge cases:
  - RESET_PC=0xFFFF_FFFF_FFFF_FFFC advancing once gives pc=0.
  - CNT_W=2 counter saturates at 3.
  - Asserting reset mid-stall clears all outputs asynchronously before the next clock edge.
